hazard_fwd_pipe: RTL

//  Pipeline-side partner of the register file: tracks destination/write-enable/mem-to-reg for the

---
 rtl/hazard_fwd_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_fwd_pipe.sv
// ---------------------------------------------------------------------------
// hazard_fwd_pipe
//
// Pipeline-side partner of the register file. Tracks destination, write
// enable and load (mem-to-reg) flags for the instructions in EX, MEM and WB.
// It drives the register file's forwarding inputs and its write port, and
// turns the register file's regok load-use flag into an IF/ID stall plus a
// single EX bubble per low cycle.
//
// Optional feature: define HAZARD_FWD_STATS_EN to add saturating stall and
// flush counters (stall_count / flush_count ports and STALL_CNT_W parameter).
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   id_*                  decoded instruction fields (valid, reg_write,
//                         reg_des, mem_to_reg)
//   flush                 branch taken: kill the instruction in ID
//   regok                 register file: 0 = load-use hazard on ID operands
//   ex_result             ALU result of the instruction now in EX
//   mem_rdata             data-memory read data for the instruction in MEM
//   stall_ifid            hold PC and IF/ID this cycle
//   idex_*                EX-stage forwarding info (idex_data = ex_result)
//   exmem_*               MEM-stage forwarding info
//   reg_write, write_reg,
//   write_data            registered WB write port to the register file
//   stall_count,
//   flush_count           event counters (HAZARD_FWD_STATS_EN only)
// ---------------------------------------------------------------------------
module hazard_fwd_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
`ifdef HAZARD_FWD_STATS_EN
   ,
   parameter int STALL_CNT_W = 16
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_reg_des,
   input  logic              id_mem_to_reg,
   input  logic              flush,
   input  logic              regok,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_ifid,
   output logic              idex_reg_write,
   output logic [REG_AW-1:0] idex_reg_des,
   output logic              idex_mem_to_reg,
   output logic [DATA_W-1:0] idex_data,
   output logic              exmem_reg_write,
   output logic [REG_AW-1:0] exmem_reg_des,
   output logic [DATA_W-1:0] exmem_data,
   output logic              reg_write,
   output logic [REG_AW-1:0] write_reg,
   output logic [DATA_W-1:0] write_data
`ifdef HAZARD_FWD_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_count,
   output logic [STALL_CNT_W-1:0] flush_count
`endif
);

   logic              id_take;
   logic              exmem_mem_to_reg;
   logic [DATA_W-1:0] exmem_alu;

   // Flush wins over a load-use stall: the ID instruction is discarded anyway,
   // so holding IF/ID would only re-fetch the wrong-path instruction.
   assign stall_ifid = ~regok & ~flush & ~reset;

   // An instruction only enters EX when it is real, not killed and not stalled.
   assign id_take = id_valid & regok & ~flush;

   assign idex_data  = ex_result;
   assign exmem_data = exmem_mem_to_reg ? mem_rdata : exmem_alu;

   // NOTE: reset is synchronous, so it sits inside the clocked branch; every
   // pipeline register is cleared on the same edge, turning all stages into bubbles.
   always_ff @(posedge clock) begin
      if (reset) begin
         idex_reg_write   <= 1'b0;
         idex_reg_des     <= '0;
         idex_mem_to_reg  <= 1'b0;
         exmem_reg_write  <= 1'b0;
         exmem_reg_des    <= '0;
         exmem_mem_to_reg <= 1'b0;
         exmem_alu        <= '0;
         reg_write        <= 1'b0;
         write_reg        <= '0;
         write_data       <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value on this edge, which is what makes it a pipeline.
         if (id_take) begin
            // Folding des != 0 into the enable keeps reg 0 writes inside the block.
            idex_reg_write  <= id_reg_write & (id_reg_des != '0);
            idex_reg_des    <= id_reg_des;
            idex_mem_to_reg <= id_mem_to_reg;
         end else begin
            idex_reg_write  <= 1'b0;
            idex_reg_des    <= '0;
            idex_mem_to_reg <= 1'b0;
         end

         exmem_reg_write  <= idex_reg_write;
         exmem_reg_des    <= idex_reg_des;
         exmem_mem_to_reg <= idex_mem_to_reg;
         exmem_alu        <= ex_result;

         // Registered WB port: stable for the whole cycle around the register
         // file's falling-edge write.
         reg_write  <= exmem_reg_write;
         write_reg  <= exmem_reg_des;
         write_data <= exmem_data;
      end
   end

`ifdef HAZARD_FWD_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_ifid && (stall_count != '1)) stall_count <= stall_count + 1'b1;
         if (flush && (flush_count != '1))      flush_count <= flush_count + 1'b1;
      end
   end
`endif

endmodule
